// File: rtl/sum_divider_pkg.sv
// Shared definitions for sum_normalizing_divider: FSM states, default widths,
// iteration count / counter width derivation and quotient limit helpers.
package sum_divider_pkg;

    localparam int WORK_W = 24;
    localparam int QUOT_W = 16;
    localparam int QUOT_F = 15;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DIVIDE,
        S_FINISH
    } state_t;

    // One quotient bit per dividend bit of |N|*2^qf.
    function automatic int iter_count(int ww, int qf);
        return ww + qf;
    endfunction

    function automatic int cnt_width(int iter);
        return $clog2(iter + 1);
    endfunction

    function automatic longint unsigned quot_max(int qw);
        return (64'd1 << (qw - 1)) - 64'd1;
    endfunction

    function automatic longint unsigned quot_min_mag(int qw);
        return 64'd1 << (qw - 1);
    endfunction

endpackage

// File: rtl/restoring_div_core.sv
// Unsigned restoring long-division core, one quotient bit per step.
// Ports: clk, rst_n, i_load/i_dividend/i_divisor start, i_step advance,
// o_quot result magnitude, o_last high during the final step.
module restoring_div_core #(
    parameter int DW = 39,
    parameter int VW = 24,
    parameter int CW = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_load,
    input  logic          i_step,
    input  logic [DW-1:0] i_dividend,
    input  logic [VW-1:0] i_divisor,
    output logic [DW-1:0] o_quot,
    output logic          o_last
);

    logic [VW-1:0] r_rem;
    logic [VW-1:0] r_div;
    logic [DW-1:0] r_quo;
    logic [CW-1:0] r_cnt;

    logic [VW:0]   w_trial;
    logic [VW:0]   w_diff;
    logic          w_ge;

    // r_quo shifts dividend bits out of the top while quotient bits enter below.
    assign w_trial = {r_rem, r_quo[DW-1]};
    assign w_diff  = w_trial - {1'b0, r_div};
    assign w_ge    = ~w_diff[VW];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem <= '0;
            r_div <= '0;
            r_quo <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_rem <= '0;
            r_div <= i_divisor;
            r_quo <= i_dividend;
            r_cnt <= CW'(DW);
        end else if (i_step && (r_cnt != '0)) begin
            r_rem <= w_ge ? w_diff[VW-1:0] : w_trial[VW-1:0];
            r_quo <= {r_quo[DW-2:0], w_ge};
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign o_quot = r_quo;
    assign o_last = (r_cnt == CW'(1));

endmodule

// File: rtl/sum_normalizing_divider.sv
// Signed fixed-point divider: numerator / sumForDivision over valid/ready.
// Ports: clk, reset (async, active-low), numerator, sumForDivision, in_valid,
// in_ready, quotient, out_valid, div_by_zero, overflow.
// Define SUM_DIVIDER_SATURATION_EN to clamp out-of-range results.
module sum_normalizing_divider
    import sum_divider_pkg::*;
#(
    parameter int workingBitSize = WORK_W,
    parameter int quotBitSize    = QUOT_W,
    parameter int quotFracSize   = QUOT_F
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [workingBitSize-1:0] numerator,
    input  logic [workingBitSize-1:0] sumForDivision,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [quotBitSize-1:0]    quotient,
    output logic                      out_valid,
    output logic                      div_by_zero,
    output logic                      overflow
);

    localparam int WW   = workingBitSize;
    localparam int QW   = quotBitSize;
    localparam int ITER = iter_count(WW, quotFracSize);
    localparam int CW   = cnt_width(ITER);

    localparam logic [WW-1:0] ONE_W = WW'(1);
    localparam logic [QW-1:0] ONE_Q = QW'(1);
    localparam logic [QW-1:0] Q_MAX = QW'(quot_max(QW));
    localparam logic [QW-1:0] Q_MIN = {1'b1, {(QW-1){1'b0}}};

    state_t          r_state;
    state_t          w_next;
    logic [WW-1:0]   r_num;
    logic [WW-1:0]   r_den;
    logic            r_neg;
    logic            r_zero_den;
    logic [QW-1:0]   r_quot;
    logic            r_valid;
    logic            r_dbz;

    logic            w_xfer;
    logic            w_load;
    logic            w_step;
    logic            w_last;
    logic [WW-1:0]   w_abs_n;
    logic [WW-1:0]   w_abs_d;
    logic [ITER-1:0] w_mag;
    logic [QW-1:0]   w_wrap;
    logic [QW-1:0]   w_q;

    assign w_xfer = in_valid && (r_state == S_IDLE);

    // WW bits suffice: |most negative| reads correctly as unsigned.
    assign w_abs_n = r_num[WW-1] ? (~r_num + ONE_W) : r_num;
    assign w_abs_d = r_den[WW-1] ? (~r_den + ONE_W) : r_den;

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_step = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (in_valid) w_next = S_LOAD;
            end
            S_LOAD: begin
                if (r_den == '0) begin
                    w_next = S_FINISH;
                end else begin
                    w_load = 1'b1;
                    w_next = S_DIVIDE;
                end
            end
            S_DIVIDE: begin
                w_step = 1'b1;
                if (w_last) w_next = S_FINISH;
            end
            S_FINISH: begin
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    restoring_div_core #(
        .DW (ITER),
        .VW (WW),
        .CW (CW)
    ) u_core (
        .clk        (clk),
        .rst_n      (reset),
        .i_load     (w_load),
        .i_step     (w_step),
        .i_dividend ({w_abs_n, {quotFracSize{1'b0}}}),
        .i_divisor  (w_abs_d),
        .o_quot     (w_mag),
        .o_last     (w_last)
    );

    assign w_wrap = r_neg ? (~w_mag[QW-1:0] + ONE_Q) : w_mag[QW-1:0];

`ifdef SUM_DIVIDER_SATURATION_EN
    localparam logic [ITER-1:0] MAG_MAX = ITER'(quot_max(QW));
    localparam logic [ITER-1:0] MAG_MIN = ITER'(quot_min_mag(QW));

    logic w_ovf;
    logic r_ovf;

    always_comb begin
        w_q   = '0;
        w_ovf = 1'b0;
        if (r_zero_den) begin
            if (r_num[WW-1]) w_q = Q_MIN;
            else if (|r_num) w_q = Q_MAX;
        end else if (!r_neg && (w_mag > MAG_MAX)) begin
            w_q   = Q_MAX;
            w_ovf = 1'b1;
        end else if (r_neg && (w_mag > MAG_MIN)) begin
            w_q   = Q_MIN;
            w_ovf = 1'b1;
        end else begin
            w_q = w_wrap;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ovf <= 1'b0;
        end else if (r_state == S_FINISH) begin
            r_ovf <= w_ovf;
        end
    end

    assign overflow = r_ovf;
`else
    // High magnitude bits only matter to the range check, which is absent.
    logic w_unused_hi;
    assign w_unused_hi = |w_mag[ITER-1:QW];

    always_comb begin
        w_q = w_wrap;
        if (r_zero_den) begin
            w_q = '0;
            if (r_num[WW-1]) w_q = Q_MIN;
            else if (|r_num) w_q = Q_MAX;
        end
    end

    assign overflow = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_num      <= '0;
            r_den      <= '0;
            r_neg      <= 1'b0;
            r_zero_den <= 1'b0;
            r_quot     <= '0;
            r_valid    <= 1'b0;
            r_dbz      <= 1'b0;
        end else begin
            r_state <= w_next;
            r_valid <= (r_state == S_FINISH);
            if (w_xfer) begin
                r_num <= numerator;
                r_den <= sumForDivision;
            end
            if (r_state == S_LOAD) begin
                r_neg      <= r_num[WW-1] ^ r_den[WW-1];
                r_zero_den <= (r_den == '0);
            end
            if (r_state == S_FINISH) begin
                r_quot <= w_q;
                r_dbz  <= r_zero_den;
            end
        end
    end

    assign in_ready    = (r_state == S_IDLE);
    assign quotient    = r_quot;
    assign out_valid   = r_valid;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_sum_normalizing_divider.sv
// Directed self-checking bench for sum_normalizing_divider.
// Expected quotients are hand-computed Q1.15 values at default widths.
module tb_sum_normalizing_divider;

    logic        clk = 1'b0;
    logic        reset;
    logic [23:0] numerator;
    logic [23:0] sumForDivision;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] quotient;
    logic        out_valid;
    logic        div_by_zero;
    logic        overflow;

    int errors = 0;
    int checks = 0;

    sum_normalizing_divider dut (
        .clk            (clk),
        .reset          (reset),
        .numerator      (numerator),
        .sumForDivision (sumForDivision),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .quotient       (quotient),
        .out_valid      (out_valid),
        .div_by_zero    (div_by_zero),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run(input string tag, input logic [23:0] n,
                       input logic [23:0] d, input int elat,
                       input logic [15:0] eq, input logic edbz,
                       input logic eovf);
        int lat;
        numerator      = n;
        sumForDivision = d;
        in_valid       = 1'b1;
        @(posedge clk);
        #1;
        in_valid       = 1'b0;
        numerator      = ~n;
        sumForDivision = d ^ 24'h5A5A5A;
        chk({tag, "_busy"}, 32'(in_ready), 32'd0);
        wait_valid(lat);
        chk({tag, "_lat"}, 32'(lat), 32'(elat));
        chk({tag, "_q"}, 32'(quotient), 32'(eq));
        chk({tag, "_dbz"}, 32'(div_by_zero), 32'(edbz));
        chk({tag, "_ovf"}, 32'(overflow), 32'(eovf));
        chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        chk({tag, "_pulse"}, 32'(out_valid), 32'd0);
        chk({tag, "_hold"}, 32'(quotient), 32'(eq));
    endtask

    initial begin
        int lat;
        int pulses;
        logic sat;
`ifdef SUM_DIVIDER_SATURATION_EN
        sat = 1'b1;
`else
        sat = 1'b0;
`endif
        reset          = 1'b0;
        in_valid       = 1'b0;
        numerator      = '0;
        sumForDivision = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_q", 32'(quotient), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_dbz", 32'(div_by_zero), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_rdy", 32'(in_ready), 32'd1);

        run("pos", 24'h040000, 24'h080000, 41, 16'h4000, 1'b0, 1'b0);
        run("negn", 24'hFC0000, 24'h080000, 41, 16'hC000, 1'b0, 1'b0);
        run("negd", 24'h040000, 24'hF80000, 41, 16'hC000, 1'b0, 1'b0);
        run("m1", 24'hF80000, 24'h080000, 41, 16'h8000, 1'b0, 1'b0);
        run("trunc", 24'h01999A, 24'h100000, 41, 16'h0CCC, 1'b0, 1'b0);
        run("trneg", 24'hFE6666, 24'h100000, 41, 16'hF334, 1'b0, 1'b0);
        if (sat) begin
            run("ovp", 24'h0C0000, 24'h080000, 41, 16'h7FFF, 1'b0, 1'b1);
            run("ovn", 24'h800000, 24'h100000, 41, 16'h8000, 1'b0, 1'b1);
        end else begin
            run("ovp", 24'h0C0000, 24'h080000, 41, 16'hC000, 1'b0, 1'b0);
            run("ovn", 24'h800000, 24'h100000, 41, 16'h0000, 1'b0, 1'b0);
        end
        run("dz0", 24'h000000, 24'h000000, 2, 16'h0000, 1'b1, 1'b0);
        run("dzn", 24'hE00000, 24'h000000, 2, 16'h8000, 1'b1, 1'b0);
        run("dzp", 24'h01999A, 24'h000000, 2, 16'h7FFF, 1'b1, 1'b0);

        numerator      = 24'h040000;
        sumForDivision = 24'h080000;
        in_valid       = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("mid_q", 32'(quotient), 32'd0);
        chk("mid_dbz", 32'(div_by_zero), 32'd0);
        chk("mid_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        chk("mid_rdy", 32'(in_ready), 32'd1);
        pulses = 0;
        repeat (50) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) pulses++;
        end
        chk("mid_nopulse", 32'(pulses), 32'd0);
        run("post", 24'h040000, 24'h080000, 41, 16'h4000, 1'b0, 1'b0);

        numerator      = 24'h040000;
        sumForDivision = 24'h080000;
        in_valid       = 1'b1;
        @(posedge clk);
        #1;
        chk("b2b_busy1", 32'(in_ready), 32'd0);
        numerator      = 24'h7FFFFF;
        sumForDivision = 24'h000001;
        repeat (20) @(posedge clk);
        #1;
        numerator      = 24'h0C0000;
        sumForDivision = 24'h100000;
        wait_valid(lat);
        chk("b2b_lat1", 32'(lat + 20), 32'd41);
        chk("b2b_q1", 32'(quotient), 32'h4000);
        chk("b2b_rdy1", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid       = 1'b0;
        numerator      = 24'h123456;
        sumForDivision = 24'h000000;
        chk("b2b_busy2", 32'(in_ready), 32'd0);
        wait_valid(lat);
        chk("b2b_lat2", 32'(lat), 32'd41);
        chk("b2b_q2", 32'(quotient), 32'h6000);
        chk("b2b_dbz2", 32'(div_by_zero), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
